// File: rtl/fp32_to_int32_seq.sv
// Multi-cycle FP32 -> signed int32 converter with valid/ready handshakes and an iterative shifter.
// Optional round-toward-zero input enabled by defining FP32_TO_INT32_RTZ_EN.
module fp32_to_int32_seq #(
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] src,
`ifdef FP32_TO_INT32_RTZ_EN
  input  logic        rtz,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        invalid,
  output logic        inexact
);

  generate
    if (!(SHIFT_STEP == 1 || SHIFT_STEP == 2 || SHIFT_STEP == 4 || SHIFT_STEP == 8)) begin : g_bad_step
      $error("fp32_to_int32_seq: SHIFT_STEP must be 1, 2, 4 or 8");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);

  logic [1:0]  state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic [4:0]  rem_q, rem_d;
  logic        left_q, left_d;
  logic        special_q, special_d;
  logic [31:0] spec_out_q, spec_out_d;
  logic        spec_inv_q, spec_inv_d;
  logic        rtz_q, rtz_d;
  logic [31:0] out_q, out_d;
  logic        invalid_q, invalid_d;
  logic        inexact_q, inexact_d;

  logic [7:0]  src_exp;
  logic [22:0] src_frac;
  assign src_exp  = src[30:23];
  assign src_frac = src[22:0];

  // Operand classification, evaluated combinationally on the input word.
  logic        c_special;
  logic [31:0] c_spec_out;
  logic        c_spec_inv;
  logic [31:0] c_mag;
  logic        c_sticky;
  logic        c_left;
  logic [4:0]  c_k;

  always_comb begin
    c_special  = 1'b0;
    c_spec_out = 32'd0;
    c_spec_inv = 1'b0;
    c_mag      = {8'd0, 1'b1, src_frac};
    c_sticky   = 1'b0;
    c_left     = 1'b0;
    c_k        = 5'd0;
    if (src_exp == 8'hFF && src_frac != 23'd0) begin
      c_special  = 1'b1;
      c_spec_out = 32'h7FFF_FFFF;
      c_spec_inv = 1'b1;
    end else if (src_exp >= 8'd158) begin
      c_special = 1'b1;
      if (src == 32'hCF00_0000) begin
        c_spec_out = 32'h8000_0000;
      end else begin
        c_spec_out = src[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        c_spec_inv = 1'b1;
      end
    end else if (src_exp < 8'd126) begin
      // Magnitude below one half: result is zero, only the inexact flag matters.
      c_mag    = 32'd0;
      c_sticky = (src_exp != 8'd0) || (src_frac != 23'd0);
    end else if (src_exp >= 8'd150) begin
      c_left = 1'b1;
      c_k    = 5'(src_exp - 8'd150);
    end else begin
      c_k = 5'(8'd150 - src_exp);
    end
  end

  // One iteration of the shifter: amount is min(STEP, remaining).
  logic [4:0] step_amt;
  logic [7:0] below_mask;
  logic       shift_guard;
  logic       shift_sticky;

  assign step_amt = (rem_q < STEP) ? rem_q : STEP;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      assign below_mask[gi] = (5'(gi + 1) < step_amt);
    end
  endgenerate

  assign shift_guard  = mag_q[step_amt - 5'd1];
  assign shift_sticky = sticky_q | guard_q | (|(mag_q[7:0] & below_mask));

  logic        round_up;
  logic [31:0] rounded;
  assign round_up = guard_q & (sticky_q | mag_q[0]) & ~rtz_q;
  assign rounded  = mag_q + {31'd0, round_up};

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    guard_d    = guard_q;
    sticky_d   = sticky_q;
    rem_d      = rem_q;
    left_d     = left_q;
    special_d  = special_q;
    spec_out_d = spec_out_q;
    spec_inv_d = spec_inv_q;
    rtz_d      = rtz_q;
    out_d      = out_q;
    invalid_d  = invalid_q;
    inexact_d  = inexact_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d     = src[31];
          mag_d      = c_mag;
          guard_d    = 1'b0;
          sticky_d   = c_sticky;
          rem_d      = c_k;
          left_d     = c_left;
          special_d  = c_special;
          spec_out_d = c_spec_out;
          spec_inv_d = c_spec_inv;
`ifdef FP32_TO_INT32_RTZ_EN
          rtz_d      = rtz;
`else
          rtz_d      = 1'b0;
`endif
          state_d    = (c_k != 5'd0) ? ST_SHIFT : ST_ROUND;
        end
      end
      ST_SHIFT: begin
        if (left_q) begin
          mag_d = mag_q << step_amt;
        end else begin
          mag_d    = mag_q >> step_amt;
          guard_d  = shift_guard;
          sticky_d = shift_sticky;
        end
        rem_d = rem_q - step_amt;
        if (rem_q == step_amt) begin
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (special_q) begin
          out_d     = spec_out_q;
          invalid_d = spec_inv_q;
          inexact_d = 1'b0;
        end else begin
          // e <= 157 bounds the magnitude, so the increment cannot overflow.
          out_d     = sign_q ? (32'd0 - rounded) : rounded;
          invalid_d = 1'b0;
          inexact_d = guard_q | sticky_q;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sign_q     <= 1'b0;
      mag_q      <= 32'd0;
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
      rem_q      <= 5'd0;
      left_q     <= 1'b0;
      special_q  <= 1'b0;
      spec_out_q <= 32'd0;
      spec_inv_q <= 1'b0;
      rtz_q      <= 1'b0;
      out_q      <= 32'd0;
      invalid_q  <= 1'b0;
      inexact_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      guard_q    <= guard_d;
      sticky_q   <= sticky_d;
      rem_q      <= rem_d;
      left_q     <= left_d;
      special_q  <= special_d;
      spec_out_q <= spec_out_d;
      spec_inv_q <= spec_inv_d;
      rtz_q      <= rtz_d;
      out_q      <= out_d;
      invalid_q  <= invalid_d;
      inexact_q  <= inexact_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;
  assign invalid   = invalid_q;
  assign inexact   = inexact_q;

endmodule
